// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the two-port memory unit.
//   DEF_MEM_WIDTH / DEF_MEM_DEPTH / DEF_ADDR_SIZE : default parameter values
//   state_e : controller state (CLEAR while zeroing the array, READY for access)
//   rsrc_e  : where a port's read data currently comes from
package mem_pkg;

    localparam int unsigned DEF_MEM_WIDTH = 16;
    localparam int unsigned DEF_MEM_DEPTH = 1024;
    localparam int unsigned DEF_ADDR_SIZE = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // SRC_ZERO: reset or out-of-range read, SRC_MEM: array read register,
    // SRC_FWD: data captured from a same-cycle write.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_FWD  = 2'd2
    } rsrc_e;

    // Index width for an array of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array_2p.sv
// mem_array_2p: plain storage with two write ports and two registered read
// ports. No reset; contents are only changed by writes.
//   clk              : clock, all updates on rising edge
//   we1/wa1/wd1      : write port 1 (wins over port 2 on the same index)
//   we2/wa2/wd2      : write port 2
//   re1/ra1 -> rd1   : read port 1, rd1 loads old contents when re1, else holds
//   re2/ra2 -> rd2   : read port 2, same behaviour
module mem_array_2p #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we1,
    input  logic [IDX_W-1:0]  wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [IDX_W-1:0]  wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic              re1,
    input  logic [IDX_W-1:0]  ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic              re2,
    input  logic [IDX_W-1:0]  ra2,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    // Port 2 is written first so port 1 takes precedence on a shared index.
    always_ff @(posedge clk) begin
        if (we2) mem_q[wa2] <= wd2;
        if (we1) mem_q[wa1] <= wd1;
    end

    // Read registers load on strobe and hold otherwise.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (re1) rd1_d = mem_q[ra1];
        if (re2) rd2_d = mem_q[ra2];
    end

    always_ff @(posedge clk) begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
    end

    assign rd1 = rd1_q;
    assign rd2 = rd2_q;

endmodule

// File: rtl/mem_unit_2p.sv
// mem_unit_2p: two-port memory with power-up clear, write-first forwarding,
// collision detection and address range checking.
//   clk, reset_n          : clock (rising edge), async active-low reset
//   A1/A2, W1/W2          : per-port address and write data
//   Write1/Write2         : per-port write strobes
//   Read1/Read2           : per-port read strobes
//   R1/R2                 : per-port read data, updated one cycle after a read
//   R1_valid/R2_valid     : one-cycle pulse with new read data
//   busy                  : high while the array is being cleared
//   addr_err              : pulse when an accepted strobe is out of range
//   collision             : pulse when both ports write the same in-range word
module mem_unit_2p
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_SIZE-1:0] A1,
    input  logic [ADDR_SIZE-1:0] A2,
    input  logic [MEM_WIDTH-1:0] W1,
    input  logic [MEM_WIDTH-1:0] W2,
    input  logic                 Write1,
    input  logic                 Write2,
    input  logic                 Read1,
    input  logic                 Read2,
    output logic [MEM_WIDTH-1:0] R1,
    output logic [MEM_WIDTH-1:0] R2,
    output logic                 R1_valid,
    output logic                 R2_valid,
    output logic                 busy,
    output logic                 addr_err,
    output logic                 collision
);

    localparam int unsigned IDX_W = idx_width(MEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int unsigned CMP_W = ADDR_SIZE + 1;

    // One extra bit lets MEM_DEPTH == 2**ADDR_SIZE compare correctly.
    localparam logic [CMP_W-1:0] DEPTH_CMP = CMP_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_DEPTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                 busy_q, busy_d;
    logic                 v1_q, v1_d, v2_q, v2_d;
    logic                 aerr_q, aerr_d;
    logic                 coll_q, coll_d;
    rsrc_e                src1_q, src1_d, src2_q, src2_d;
    logic [MEM_WIDTH-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    logic                 in1_c, in2_c;
    logic                 same_addr_c;
    logic                 wr1_ok_c, wr2_ok_c;
    logic [IDX_W-1:0]     idx1_c, idx2_c;

    logic                 arr_we1, arr_we2, arr_re1, arr_re2;
    logic [IDX_W-1:0]     arr_wa1, arr_wa2;
    logic [MEM_WIDTH-1:0] arr_wd1, arr_wd2;
    logic [MEM_WIDTH-1:0] arr_rd1, arr_rd2;

    // Full-width range check; index is only used when in range.
    assign in1_c       = ({1'b0, A1} < DEPTH_CMP);
    assign in2_c       = ({1'b0, A2} < DEPTH_CMP);
    assign same_addr_c = (A1 == A2);
    assign wr1_ok_c    = Write1 && in1_c;
    assign wr2_ok_c    = Write2 && in2_c;
    assign idx1_c      = IDX_W'(A1);
    assign idx2_c      = IDX_W'(A2);

    // Next-state, array control and forwarding decisions.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        v1_d      = 1'b0;
        v2_d      = 1'b0;
        aerr_d    = 1'b0;
        coll_d    = 1'b0;
        src1_d    = src1_q;
        src2_d    = src2_q;
        fwd1_d    = fwd1_q;
        fwd2_d    = fwd2_q;
        arr_we1   = 1'b0;
        arr_wa1   = idx1_c;
        arr_wd1   = W1;
        arr_we2   = 1'b0;
        arr_wa2   = idx2_c;
        arr_wd2   = W2;
        arr_re1   = 1'b0;
        arr_re2   = 1'b0;

        unique case (state_q)
            CLEAR: begin
                // Zero one word per cycle through write port 1; strobes ignored.
                arr_we1   = 1'b1;
                arr_wa1   = IDX_W'(clr_cnt_q);
                arr_wd1   = '0;
                clr_cnt_d = clr_cnt_q + CNT_W'(1);
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                arr_we1 = wr1_ok_c;
                // Port 1 owns a shared address, so port 2 is suppressed there.
                arr_we2 = wr2_ok_c && !(wr1_ok_c && same_addr_c);
                coll_d  = wr1_ok_c && wr2_ok_c && same_addr_c;
                aerr_d  = ((Write1 || Read1) && !in1_c) ||
                          ((Write2 || Read2) && !in2_c);

                // Write-first: a same-cycle write to the read address is forwarded.
                if (Read1) begin
                    v1_d = 1'b1;
                    if (!in1_c) begin
                        src1_d = SRC_ZERO;
                    end else if (wr1_ok_c) begin
                        src1_d = SRC_FWD;
                        fwd1_d = W1;
                    end else if (wr2_ok_c && same_addr_c) begin
                        src1_d = SRC_FWD;
                        fwd1_d = W2;
                    end else begin
                        src1_d  = SRC_MEM;
                        arr_re1 = 1'b1;
                    end
                end

                if (Read2) begin
                    v2_d = 1'b1;
                    if (!in2_c) begin
                        src2_d = SRC_ZERO;
                    end else if (wr1_ok_c && same_addr_c) begin
                        src2_d = SRC_FWD;
                        fwd2_d = W1;
                    end else if (wr2_ok_c) begin
                        src2_d = SRC_FWD;
                        fwd2_d = W2;
                    end else begin
                        src2_d  = SRC_MEM;
                        arr_re2 = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            aerr_q    <= 1'b0;
            coll_q    <= 1'b0;
            src1_q    <= SRC_ZERO;
            src2_q    <= SRC_ZERO;
            fwd1_q    <= '0;
            fwd2_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            aerr_q    <= aerr_d;
            coll_q    <= coll_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            fwd1_q    <= fwd1_d;
            fwd2_q    <= fwd2_d;
        end
    end

    mem_array_2p #(
        .DATA_W (MEM_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk (clk),
        .we1 (arr_we1),
        .wa1 (arr_wa1),
        .wd1 (arr_wd1),
        .we2 (arr_we2),
        .wa2 (arr_wa2),
        .wd2 (arr_wd2),
        .re1 (arr_re1),
        .ra1 (idx1_c),
        .rd1 (arr_rd1),
        .re2 (arr_re2),
        .ra2 (idx2_c),
        .rd2 (arr_rd2)
    );

    // Read data is selected purely from flops; the resettable source select
    // gives zero on reset even though the array read registers have no reset.
    always_comb begin
        unique case (src1_q)
            SRC_MEM: R1 = arr_rd1;
            SRC_FWD: R1 = fwd1_q;
            default: R1 = '0;
        endcase
        unique case (src2_q)
            SRC_MEM: R2 = arr_rd2;
            SRC_FWD: R2 = fwd2_q;
            default: R2 = '0;
        endcase
    end

    assign R1_valid  = v1_q;
    assign R2_valid  = v2_q;
    assign busy      = busy_q;
    assign addr_err  = aerr_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_mem_unit_2p.sv
// tb_mem_unit_2p: directed scoreboard bench. Instance a uses a 16-word array,
// instance b a 1000-word array for the non-power-of-two range checks.
module tb_mem_unit_2p;

    logic        clk;

    logic        rst_a, wr1_a, wr2_a, rd1_a, rd2_a;
    logic [15:0] a1_a, a2_a, w1_a, w2_a, r1_a, r2_a;
    logic        v1_a, v2_a, busy_a, aerr_a, coll_a;

    logic        rst_b, wr1_b, wr2_b, rd1_b, rd2_b;
    logic [15:0] a1_b, a2_b, w1_b, w2_b, r1_b, r2_b;
    logic        v1_b, v2_b, busy_b, aerr_b, coll_b;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] last1, last2;
    logic        exp_aerr, exp_coll;
    int          n;

    mem_unit_2p #(.MEM_WIDTH(16), .MEM_DEPTH(16), .ADDR_SIZE(16)) dut_a (
        .clk(clk), .reset_n(rst_a), .A1(a1_a), .A2(a2_a), .W1(w1_a), .W2(w2_a),
        .Write1(wr1_a), .Write2(wr2_a), .Read1(rd1_a), .Read2(rd2_a),
        .R1(r1_a), .R2(r2_a), .R1_valid(v1_a), .R2_valid(v2_a),
        .busy(busy_a), .addr_err(aerr_a), .collision(coll_a)
    );

    mem_unit_2p #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADDR_SIZE(16)) dut_b (
        .clk(clk), .reset_n(rst_b), .A1(a1_b), .A2(a2_b), .W1(w1_b), .W2(w2_b),
        .Write1(wr1_b), .Write2(wr2_b), .Read1(rd1_b), .Read2(rd2_b),
        .R1(r1_b), .R2(r2_b), .R1_valid(v1_b), .R2_valid(v2_b),
        .busy(busy_b), .addr_err(aerr_b), .collision(coll_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        wr1_a = 0; wr2_a = 0; rd1_a = 0; rd2_a = 0;
        a1_a = 0; a2_a = 0; w1_a = 0; w2_a = 0;
        exp_aerr = 0; exp_coll = 0;
    endtask

    task automatic idle_b();
        wr1_b = 0; wr2_b = 0; rd1_b = 0; rd2_b = 0;
        a1_b = 0; a2_b = 0; w1_b = 0; w2_b = 0;
    endtask

    // One clock on instance a, then compare every output against the scoreboard.
    task automatic cyc_a();
        logic [15:0] e;
        @(posedge clk); #1;
        if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("r1_valid", 32'(v1_a), 32'd1);
            chk("r1_data", 32'(r1_a), 32'(e));
            last1 = e;
        end else begin
            chk("r1_valid", 32'(v1_a), 32'd0);
            chk("r1_hold", 32'(r1_a), 32'(last1));
        end
        if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("r2_valid", 32'(v2_a), 32'd1);
            chk("r2_data", 32'(r2_a), 32'(e));
            last2 = e;
        end else begin
            chk("r2_valid", 32'(v2_a), 32'd0);
            chk("r2_hold", 32'(r2_a), 32'(last2));
        end
        chk("addr_err", 32'(aerr_a), 32'(exp_aerr));
        chk("collision", 32'(coll_a), 32'(exp_coll));
        idle_a();
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_r1"}, 32'(r1_a), 32'd0);
        chk({tag, "_r2"}, 32'(r2_a), 32'd0);
        chk({tag, "_v1"}, 32'(v1_a), 32'd0);
        chk({tag, "_v2"}, 32'(v2_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd1);
        chk({tag, "_aerr"}, 32'(aerr_a), 32'd0);
        chk({tag, "_coll"}, 32'(coll_a), 32'd0);
    endtask

    initial begin
        idle_a(); idle_b();
        rst_a = 0; rst_b = 0;
        last1 = 0; last2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("reset");

        // Release with strobes active through the whole clear; all ignored.
        rst_a = 1;
        chk("busy_release", 32'(busy_a), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            wr1_a = 1; a1_a = 16'd2; w1_a = 16'hAAAA; rd1_a = 1;
            wr2_a = 1; w2_a = 16'h5A5A; rd2_a = 1;
            a2_a = (i % 2 == 1) ? 16'd2 : 16'd20;
            cyc_a();
            chk("busy_clear", 32'(busy_a), (i < 16) ? 32'd1 : 32'd0);
        end

        // First reads after clear.
        rd1_a = 1; a1_a = 16'd5; q1.push_back(16'h0000);
        rd2_a = 1; a2_a = 16'd2; q2.push_back(16'h0000);
        cyc_a();

        // Cross-port read during write.
        wr1_a = 1; a1_a = 16'd3; w1_a = 16'hBEEF;
        rd2_a = 1; a2_a = 16'd3; q2.push_back(16'hBEEF);
        cyc_a();

        // Same-port read during write, plus stored value on the other port.
        wr1_a = 1; rd1_a = 1; a1_a = 16'd4; w1_a = 16'h1234; q1.push_back(16'h1234);
        rd2_a = 1; a2_a = 16'd3; q2.push_back(16'hBEEF);
        cyc_a();

        // Port 2 write forwarded to a port 1 read.
        wr2_a = 1; a2_a = 16'd6; w2_a = 16'h6666;
        rd1_a = 1; a1_a = 16'd6; q1.push_back(16'h6666);
        cyc_a();

        // Same-address double write: port 1 wins, collision pulses.
        wr1_a = 1; a1_a = 16'd7; w1_a = 16'h1111;
        wr2_a = 1; rd2_a = 1; a2_a = 16'd7; w2_a = 16'h2222; q2.push_back(16'h1111);
        exp_coll = 1;
        cyc_a();
        rd1_a = 1; a1_a = 16'd7; q1.push_back(16'h1111);
        cyc_a();

        // Distinct-address double write.
        wr1_a = 1; a1_a = 16'd8; w1_a = 16'h8888;
        wr2_a = 1; a2_a = 16'd9; w2_a = 16'h9999;
        cyc_a();
        rd1_a = 1; a1_a = 16'd8; q1.push_back(16'h8888);
        rd2_a = 1; a2_a = 16'd9; q2.push_back(16'h9999);
        cyc_a();
        cyc_a();

        // Out of range on both ports: single error pulse, write dropped.
        rd1_a = 1; a1_a = 16'd16; q1.push_back(16'h0000);
        wr2_a = 1; a2_a = 16'h0013; w2_a = 16'h5555;
        exp_aerr = 1;
        cyc_a();
        wr1_a = 1; a1_a = 16'h8003; w1_a = 16'h7777;
        exp_aerr = 1;
        cyc_a();
        rd1_a = 1; a1_a = 16'd3; q1.push_back(16'hBEEF);
        rd2_a = 1; a2_a = 16'h0013; q2.push_back(16'h0000);
        exp_aerr = 1;
        cyc_a();
        rd1_a = 1; a1_a = 16'd15; q1.push_back(16'h0000);
        rd2_a = 1; a2_a = 16'hFFFF; q2.push_back(16'h0000);
        exp_aerr = 1;
        cyc_a();

        // Load nonzero read data, then abort a read with reset.
        rd1_a = 1; a1_a = 16'd7; q1.push_back(16'h1111);
        rd2_a = 1; a2_a = 16'd3; q2.push_back(16'hBEEF);
        cyc_a();
        rd1_a = 1; a1_a = 16'd8;
        #2;
        rst_a = 0;
        #1;
        chk_reset_a("abort");
        last1 = 0; last2 = 0;
        cyc_a();

        // Reset again at clear count 8; clear restarts from the beginning.
        rst_a = 1;
        repeat (8) cyc_a();
        rst_a = 0;
        #1;
        chk_reset_a("midclear");
        cyc_a();
        rst_a = 1;
        for (int i = 1; i <= 16; i++) begin
            cyc_a();
            chk("busy_reclear", 32'(busy_a), (i < 16) ? 32'd1 : 32'd0);
        end
        rd1_a = 1; a1_a = 16'd3; q1.push_back(16'h0000);
        rd2_a = 1; a2_a = 16'd7; q2.push_back(16'h0000);
        cyc_a();

        // Instance b: 1000-word array.
        rst_b = 1;
        n = 0;
        while (busy_b && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_clear_len", 32'(n), 32'd1000);
        chk("b_busy", 32'(busy_b), 32'd0);

        wr2_b = 1; a2_b = 16'd1000; w2_b = 16'hFFFF;
        @(posedge clk); #1;
        chk("b_wr_aerr", 32'(aerr_b), 32'd1);
        chk("b_wr_v2", 32'(v2_b), 32'd0);
        chk("b_wr_coll", 32'(coll_b), 32'd0);
        idle_b();

        rd2_b = 1; a2_b = 16'd1000;
        @(posedge clk); #1;
        chk("b_rd_aerr", 32'(aerr_b), 32'd1);
        chk("b_rd_v2", 32'(v2_b), 32'd1);
        chk("b_rd_r2", 32'(r2_b), 32'd0);
        idle_b();

        rd1_b = 1; a1_b = 16'd0;
        rd2_b = 1; a2_b = 16'd488;
        @(posedge clk); #1;
        chk("b_a0_v1", 32'(v1_b), 32'd1);
        chk("b_a0_r1", 32'(r1_b), 32'd0);
        chk("b_a488_r2", 32'(r2_b), 32'd0);
        chk("b_a0_aerr", 32'(aerr_b), 32'd0);
        idle_b();

        rd1_b = 1; a1_b = 16'd999;
        @(posedge clk); #1;
        chk("b_a999_v1", 32'(v1_b), 32'd1);
        chk("b_a999_r1", 32'(r1_b), 32'd0);
        chk("b_a999_aerr", 32'(aerr_b), 32'd0);
        idle_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
